// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg
// Shared definitions for the UART transmit scheduler:
//   - sched_state_e : scheduler FSM encoding (IDLE, ARB, SEND, WAIT, GAP)
//   - sched_clog2   : ceil(log2(n)), minimum 1, for sizing index/counter fields
//   - baud_*        : default inter-frame gap / watchdog limits for baud
//                     index 0..4 (9600, 19200, 38400, 57600, 115200 baud)
//                     assuming a 50 MHz Clk.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_SEND = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4
    } sched_state_e;

    localparam int unsigned SCHED_CLK_HZ = 50_000_000;

    // Width needed to hold values 0..n-1; never less than 1 bit.
    function automatic int sched_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Clk cycles per UART bit for a baud index.
    function automatic int baud_bit_cycles(input int idx);
        case (idx)
            0:       return SCHED_CLK_HZ / 9600;
            1:       return SCHED_CLK_HZ / 19200;
            2:       return SCHED_CLK_HZ / 38400;
            3:       return SCHED_CLK_HZ / 57600;
            default: return SCHED_CLK_HZ / 115200;
        endcase
    endfunction

    // Two bit times of line idle between frames keeps receivers re-synced.
    function automatic int baud_gap(input int idx);
        return 2 * baud_bit_cycles(idx);
    endfunction

    // Twice the nominal frame time (10 bits per byte on the wire).
    function automatic int baud_timeout(input int idx, input int bytes);
        return 2 * 10 * bytes * baud_bit_cycles(idx);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
// Combinational round-robin selector.
//   pending    : per-requester mailbox-full flags
//   last_grant : index granted most recently
//   winner     : first pending index scanning last_grant+1, +2, ... mod NUM_REQ
//   valid      : any pending bit set
module uart_rr_pick
    import uart_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = sched_clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        // k runs 1..NUM_REQ so last_grant itself is checked last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!valid && pending[idx]) begin
                valid  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one DATA_WIDTH-bit UART word transmitter among NUM_REQ requesters.
// Each requester owns a one-word mailbox; a round-robin scheduler launches
// one word at a time, waits for Tx_Done (guarded by a watchdog), then holds
// the line idle for GAP_CYCLES before the next launch.
// Ports:
//   Clk, Rst       : clock, synchronous active-high reset
//   req, req_data  : per-requester request pulse and word (slice i)
//   ack, drop, err : one-cycle per-requester done / rejected / aborted pulses
//   pending        : mailbox-full flags
//   busy           : scheduler not idle
//   send_en        : one-cycle launch pulse to the transmitter
//   tx_data, tx_id : word being sent and its requester index
//   Tx_Done        : transmitter completion pulse
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int GAP_CYCLES = 16,
    parameter  int TIMEOUT    = 200000,
    localparam int ID_W       = sched_clog2(NUM_REQ)
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            drop,
    output logic [NUM_REQ-1:0]            err,
    output logic [NUM_REQ-1:0]            pending,
    output logic                          busy,
    output logic                          send_en,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic [ID_W-1:0]               tx_id,
    input  logic                          Tx_Done
);

    localparam int WD_W  = sched_clog2(TIMEOUT + 1);
    localparam int GAP_W = sched_clog2(GAP_CYCLES + 1);

    sched_state_e                          state_q, state_d;
    logic [NUM_REQ-1:0]                    pending_q, pending_d;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    mbox_q, mbox_d;
    logic [ID_W-1:0]                       last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]                 tx_data_q, tx_data_d;
    logic [ID_W-1:0]                       tx_id_q, tx_id_d;
    logic [WD_W-1:0]                       wd_q, wd_d;
    logic [GAP_W-1:0]                      gap_q, gap_d;
    logic [NUM_REQ-1:0]                    ack_q, ack_d;
    logic [NUM_REQ-1:0]                    drop_q, drop_d;
    logic [NUM_REQ-1:0]                    err_q, err_d;

    logic [ID_W-1:0]                       pick_id;
    logic                                  pick_valid;
    logic [DATA_WIDTH-1:0]                 pick_word;
    logic [NUM_REQ-1:0]                    tx_oh;
    logic [NUM_REQ-1:0]                    clr;

    uart_rr_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_pick (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .winner     (pick_id),
        .valid      (pick_valid)
    );

    // One-hot of the requester being served, and the winner's stored word.
    always_comb begin
        tx_oh     = '0;
        pick_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tx_oh[i] = (tx_id_q == ID_W'(i));
            if (pick_id == ID_W'(i)) pick_word = mbox_q[i];
        end
        clr = (state_q == S_SEND) ? tx_oh : '0;
    end

    // Mailboxes: a request landing in the SEND cycle of its own slot is
    // accepted, since the outgoing word was already copied to tx_data in ARB.
    always_comb begin
        pending_d = pending_q;
        mbox_d    = mbox_q;
        drop_d    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (!pending_q[i] || clr[i])) begin
                pending_d[i] = 1'b1;
                mbox_d[i]    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (req[i]) begin
                drop_d[i] = 1'b1;
            end else if (clr[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Scheduler FSM next-state / datapath.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tx_data_d    = tx_data_q;
        tx_id_d      = tx_id_q;
        wd_d         = wd_q;
        gap_d        = gap_q;
        ack_d        = '0;
        err_d        = '0;

        unique case (state_q)
            S_IDLE: begin
                if (|pending_q) state_d = S_ARB;
            end
            S_ARB: begin
                if (pick_valid) begin
                    tx_data_d    = pick_word;
                    tx_id_d      = pick_id;
                    last_grant_d = pick_id;
                    state_d      = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Saturate so a stuck transmitter can never wrap the count.
                if (wd_q != '1) wd_d = wd_q + 1'b1;
                if (Tx_Done || (wd_q == WD_W'(TIMEOUT - 1))) begin
                    // Tx_Done takes precedence over a coincident timeout.
                    if (Tx_Done) ack_d = tx_oh;
                    else         err_d = tx_oh;
                    gap_d = '0;
                    if (GAP_CYCLES == 0) state_d = S_IDLE;
                    else                 state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
                else                                 gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            mbox_q       <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            tx_data_q    <= '0;
            tx_id_q      <= '0;
            wd_q         <= '0;
            gap_q        <= '0;
            ack_q        <= '0;
            drop_q       <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            mbox_q       <= mbox_d;
            last_grant_q <= last_grant_d;
            tx_data_q    <= tx_data_d;
            tx_id_q      <= tx_id_d;
            wd_q         <= wd_d;
            gap_q        <= gap_d;
            ack_q        <= ack_d;
            drop_q       <= drop_d;
            err_q        <= err_d;
        end
    end

    assign ack     = ack_q;
    assign drop    = drop_q;
    assign err     = err_q;
    assign pending = pending_q;
    assign busy    = (state_q != S_IDLE);
    assign send_en = (state_q == S_SEND);
    assign tx_data = tx_data_q;
    assign tx_id   = tx_id_q;

endmodule
